mem_port_arbiter: RTL

//  Shares one single-ported unified memory between the pipeline IF stage (instruction

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/arb_perf_counter.sv | 24 ++
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and width helpers for the unified-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic {IDLE, BUSY} arb_state_e;
    typedef enum logic {OWN_IF, OWN_DM} arb_owner_e;

    // Smallest width (>=1) whose unsigned range holds v.
    function automatic int bits_for(input int v);
        for (int w = 1; w < 32; w++) begin
            if ((64'd1 << w) > 64'(v)) return w;
        end
        return 32;
    endfunction

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

    // Widths for the default build (DATA_W=32, MEM_LAT=1).
    localparam int BE_W  = be_width(32);
    localparam int LAT_W = bits_for(1);

endpackage

// File: rtl/arb_perf_counter.sv
// Saturating event counter with enable; used for stall statistics when
// ARB_PERF_CNT_EN is defined.
module arb_perf_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (en && (cnt_reg != {W{1'b1}})) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store,
// one transaction in flight. Optional stall counters: ARB_PERF_CNT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]         perf_if_stall_cnt,
    output logic [31:0]         perf_dm_stall_cnt,
`endif
    output logic                stall_if,
    output logic                stall_mem
);

    localparam int BEN_W = be_width(DATA_W);
    localparam int LW    = bits_for(MEM_LAT);
    localparam int SW    = bits_for(STARVE_MAX);

    arb_state_e  state_reg, state_next;
    arb_owner_e  owner_reg, owner_next;
    logic [LW-1:0] lat_cnt_reg, lat_cnt_next;
    logic [SW-1:0] starve_reg, starve_next;
    logic          store_reg, store_next;

    logic complete, can_grant, force_if, grant_dm, grant_if;

    // Completion cycle doubles as an arbitration slot so transfers run back-to-back.
    assign complete  = (state_reg == BUSY) && (lat_cnt_reg == LW'(1));
    assign can_grant = ~rst && ((state_reg == IDLE) || complete);
    assign force_if  = (starve_reg == SW'(STARVE_MAX));
    assign grant_dm  = can_grant && dm_req && !(if_req && force_if);
    assign grant_if  = can_grant && if_req && !grant_dm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            owner_reg   <= OWN_IF;
            lat_cnt_reg <= '0;
            starve_reg  <= '0;
            store_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            owner_reg   <= owner_next;
            lat_cnt_reg <= lat_cnt_next;
            starve_reg  <= starve_next;
            store_reg   <= store_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        owner_next   = owner_reg;
        lat_cnt_next = lat_cnt_reg;
        starve_next  = starve_reg;
        store_next   = store_reg;
        if (state_reg == BUSY) begin
            lat_cnt_next = lat_cnt_reg - 1'b1;
            if (complete) state_next = IDLE;
        end
        if (grant_dm || grant_if) begin
            state_next   = BUSY;
            owner_next   = grant_dm ? OWN_DM : OWN_IF;
            lat_cnt_next = LW'(MEM_LAT);
            store_next   = grant_dm && dm_we;
        end
        if (grant_if) begin
            starve_next = '0;
        end else if (grant_dm && if_req && !force_if) begin
            starve_next = starve_reg + 1'b1;
        end
    end

    always_comb begin
        mem_req   = grant_dm || grant_if;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_dm) begin
            mem_we    = dm_we;
            mem_be    = dm_be;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end else if (grant_if) begin
            mem_be   = {BEN_W{1'b1}};
            mem_addr = if_addr;
        end
    end

    assign if_gnt    = grant_if;
    assign dm_gnt    = grant_dm;
    assign if_rvalid = complete && (owner_reg == OWN_IF);
    assign dm_rvalid = complete && (owner_reg == OWN_DM);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign dm_rdata  = (dm_rvalid && !store_reg) ? mem_rdata : '0;
    assign stall_if  = ~rst && if_req && !grant_if;
    assign stall_mem = ~rst && dm_req && !grant_dm;

`ifdef ARB_PERF_CNT_EN
    arb_perf_counter #(.W(32)) u_if_stall_cnt (
        .clk (clk),
        .rst (rst),
        .en  (stall_if),
        .cnt (perf_if_stall_cnt)
    );

    arb_perf_counter #(.W(32)) u_dm_stall_cnt (
        .clk (clk),
        .rst (rst),
        .en  (stall_mem),
        .cnt (perf_dm_stall_cnt)
    );
`endif

endmodule
